memory_unit: RTL
================

// Module: memory_unit
// PURPOSE
// - Memory stage of the 5-stage pipelined MIPS, directly downstream of the execute stage.
// - Contents: E->M pipeline register, word-addressed data memory, M->W pipeline register, writeback result mux.
// - Outputs MU_AluOutM and MU_ResultW back to the execute-stage forwarding muxes.
// - Outputs WriteReg/RegWrite for M and W to the hazard unit.
// PARAMETERS
// - WIDTH   32   datapath width, bits
// - DEPTH   64   data memory depth in words; power of 2, >=2
// PORTS
// - MU_CLK         in   1      single clock; all state updates on rising edge
// - MU_RST         in   1      reset, synchronous, active-high
// - MU_AluOutE     in   WIDTH  ALU result (memory byte address for lw/sw)
// - MU_WriteDataE  in   WIDTH  store data, after forwarding
// - MU_WriteRegE   in   5      destination register
// - MU_RegWriteE   in   1      register-file write enable
// - MU_MemWriteE   in   1      store
// - MU_MemToRegE   in   1      load
// - MU_StallM      in   1      hold the E->M register and bubble the W stage
// - MU_AluOutM     out  WIDTH  registered ALU result (forwarding source)
// - MU_WriteRegM   out  5      M-stage destination register
// - MU_RegWriteM   out  1      M-stage register write enable
// - MU_MemToRegM   out  1      M-stage load flag (for the hazard unit)
// - MU_ResultW     out  WIDTH  MemToRegW ? ReadDataW : AluOutW
// - MU_WriteRegW   out  5      W-stage destination register
// - MU_RegWriteW   out  1      W-stage register write enable
// - MU_MisalignM   out  1      misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset (MU_RST=1 at edge): all E->M and M->W fields go to 0.
//   - Outputs are therefore 0; MU_ResultW = 0.
//   - Data memory contents are NOT reset. Simulation initialises them to 0.
// - E->M register
//   - !StallM: loads all E inputs on each edge.
//   - StallM: holds its value.
// - Memory index = AluOutM[$clog2(DEPTH)+1:2].
//   - Address bits [1:0] are ignored.
//   - Upper address bits are ignored, so the address wraps modulo DEPTH*4.
// - Read: combinational, ReadDataM = mem[index]. Latency to MU_ResultW is 1 cycle after M.
// - Write: mem[index] <= WriteDataM at the edge when MemWriteM & !StallM & !MU_RST.
// - Store then load, same address, back-to-back: the load in M sees the data written at the preceding edge (no bypass needed).
// - M->W register
//   - !StallM: captures AluOutM, ReadDataM, WriteRegM, RegWriteM, MemToRegM.
//   - StallM: captures a bubble; RegWriteW=0, other W fields keep their old values.
// - StallM and RST together: reset wins.
// - Net latency: E inputs appear on M outputs 1 edge later and on W outputs 2 edges later.
// - MU_ResultW mux is combinational from the W register.
// CONFIGURATION
// - Macro: MU_MISALIGN_TRAP_EN
// - Defined:
//   - MU_MisalignM = (MemWriteM|MemToRegM) & (AluOutM[1:0]!=0).
//   - A store with MisalignM=1 is suppressed (memory unchanged).
//   - A load with MisalignM=1 gives ReadDataW=0 and RegWriteW=0.
// - Not defined:
//   - MU_MisalignM is tied 0.
//   - Low address bits are silently ignored.
// TESTING
// - Reset: RST=1 for 2 edges -> all outputs 0, ResultW=0.
// - sw 0xDEADBEEF at addr 0x8, then lw from 0x8 next cycle -> ResultW=0xDEADBEEF 2 edges after the lw enters, RegWriteW=1.
// - R-type: AluOutE=0x1234, RegWriteE=1, WriteRegE=5, MemToRegE=0 -> AluOutM=0x1234 after 1 edge; ResultW=0x1234, WriteRegW=5 after 2 edges.
// - Wrap (DEPTH=64): sw 0x55 at 0x100, lw from 0x0 -> ResultW=0x55.
// - StallM=1 for 2 cycles with sw pending -> M regs hold, RegWriteW=0, memory unchanged; write occurs on the first edge after StallM=0.
// - MU_MISALIGN_TRAP_EN defined: sw at 0x6 -> MisalignM=1, mem[1] unchanged; lw from 0x6 -> RegWriteW=0.

Source files
------------

// File: rtl/memory_unit.sv
// Memory stage of the 5-stage pipelined MIPS: E->M register, word-addressed data
// memory, M->W register and the writeback result mux.
// Optional feature: define MU_MISALIGN_TRAP_EN to flag misaligned loads/stores,
// suppress misaligned stores and squash misaligned loads. Without it the low two
// address bits are ignored and MU_MisalignM is tied low.
module memory_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic             MU_CLK,
  input  logic             MU_RST,
  input  logic [WIDTH-1:0] MU_AluOutE,
  input  logic [WIDTH-1:0] MU_WriteDataE,
  input  logic [4:0]       MU_WriteRegE,
  input  logic             MU_RegWriteE,
  input  logic             MU_MemWriteE,
  input  logic             MU_MemToRegE,
  input  logic             MU_StallM,
  output logic [WIDTH-1:0] MU_AluOutM,
  output logic [4:0]       MU_WriteRegM,
  output logic             MU_RegWriteM,
  output logic             MU_MemToRegM,
  output logic [WIDTH-1:0] MU_ResultW,
  output logic [4:0]       MU_WriteRegW,
  output logic             MU_RegWriteW,
  output logic             MU_MisalignM
);

  localparam int unsigned AW = $clog2(DEPTH);

  // E->M pipeline register
  logic [WIDTH-1:0] alu_out_m_q;
  logic [WIDTH-1:0] write_data_m_q;
  logic [4:0]       write_reg_m_q;
  logic             reg_write_m_q;
  logic             mem_write_m_q;
  logic             mem_to_reg_m_q;

  // M->W pipeline register
  logic [WIDTH-1:0] alu_out_w_q;
  logic [WIDTH-1:0] read_data_w_q;
  logic [4:0]       write_reg_w_q;
  logic             reg_write_w_q;
  logic             mem_to_reg_w_q;

  // Data memory; contents deliberately have no reset
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    mem_idx;
  logic [WIDTH-1:0] read_data_m;
  logic             misalign_m;
  logic             store_en;
  logic             load_kill;

  // E->M register: load on every unstalled edge, hold while stalled
  always_ff @(posedge MU_CLK) begin
    if (MU_RST) begin
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_reg_m_q  <= '0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
    end else if (!MU_StallM) begin
      alu_out_m_q    <= MU_AluOutE;
      write_data_m_q <= MU_WriteDataE;
      write_reg_m_q  <= MU_WriteRegE;
      reg_write_m_q  <= MU_RegWriteE;
      mem_write_m_q  <= MU_MemWriteE;
      mem_to_reg_m_q <= MU_MemToRegE;
    end
  end

  // Word index: byte-offset bits dropped, upper bits dropped so addresses wrap
  always_comb begin
    mem_idx     = alu_out_m_q[AW+1:2];
    read_data_m = mem[mem_idx];
  end

  // Misalignment detection and its effect on stores/loads
  always_comb begin
`ifdef MU_MISALIGN_TRAP_EN
    misalign_m = (mem_write_m_q | mem_to_reg_m_q) & (alu_out_m_q[1:0] != 2'b00);
`else
    misalign_m = 1'b0;
`endif
    store_en  = mem_write_m_q & ~MU_StallM & ~misalign_m;
    load_kill = mem_to_reg_m_q & misalign_m;
  end

  // Data memory write port; a following load in M sees the data next cycle
  always_ff @(posedge MU_CLK) begin
    if (!MU_RST && store_en) begin
      mem[mem_idx] <= write_data_m_q;
    end
  end

  // M->W register: capture M on unstalled edges, insert a bubble while stalled
  always_ff @(posedge MU_CLK) begin
    if (MU_RST) begin
      alu_out_w_q    <= '0;
      read_data_w_q  <= '0;
      write_reg_w_q  <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
    end else if (MU_StallM) begin
      reg_write_w_q <= 1'b0;
    end else begin
      alu_out_w_q    <= alu_out_m_q;
      read_data_w_q  <= load_kill ? '0 : read_data_m;
      write_reg_w_q  <= write_reg_m_q;
      reg_write_w_q  <= reg_write_m_q & ~load_kill;
      mem_to_reg_w_q <= mem_to_reg_m_q;
    end
  end

  // Stage outputs and writeback result mux
  always_comb begin
    MU_AluOutM   = alu_out_m_q;
    MU_WriteRegM = write_reg_m_q;
    MU_RegWriteM = reg_write_m_q;
    MU_MemToRegM = mem_to_reg_m_q;
    MU_MisalignM = misalign_m;
    MU_ResultW   = mem_to_reg_w_q ? read_data_w_q : alu_out_w_q;
    MU_WriteRegW = write_reg_w_q;
    MU_RegWriteW = reg_write_w_q;
  end

endmodule
